multi_cycle_shift_sequencer: RTL
================================

MULTI_CYCLE_SHIFT_SEQUENCER -- requirements
Module: multi_cycle_shift_sequencer

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits, N >= 2.
REQ-002 SHALL have parameter STEP, default 3: maximum shift distance per cycle, 1 <= STEP < N.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: request present.
REQ-006 SHALL have port in_ready, output, 1: sequencer can accept a request.
REQ-007 SHALL have port in_data, input, N: unsigned operand.
REQ-008 SHALL have port in_amt, input, $clog2(N): total shift distance, 0..N-1.
REQ-009 SHALL have port in_dir, input, 1: 0 = left, 1 = right.
REQ-010 SHALL have port in_arith, input, 1: arithmetic right-shift request; honoured only per REQ-026.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port out_data, output, N: shifted result.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 SHALL assert in_ready only in IDLE; a request is accepted on a cycle with in_valid && in_ready.
REQ-017 SHALL, on acceptance, register in_data, in_amt as the remaining count, in_dir and in_arith, then enter SHIFT if in_amt != 0, else DONE.
REQ-018 SHALL, in each SHIFT cycle, shift the working register by k = min(remaining, STEP) in the latched direction and decrement remaining by k.
REQ-019 SHALL fill vacated bit positions with zeros (logical shift), except as in REQ-026.
REQ-020 SHALL move SHIFT -> DONE on the cycle where remaining reaches 0; total SHIFT cycles = ceil(in_amt/STEP).
REQ-021 SHALL assert out_valid only in DONE; latency from acceptance edge to first out_valid = 1 + ceil(in_amt/STEP) cycles.
REQ-022 SHALL hold out_data stable while out_valid && !out_ready; DONE -> IDLE on out_valid && out_ready.
REQ-023 SHALL NOT accept a new request in the cycle DONE -> IDLE (in_ready low in DONE); maximum throughput one result per 2 + ceil(amt/STEP) cycles.
REQ-024 SHALL ignore in_valid and input data outside IDLE; SHALL ignore out_ready outside DONE.

Reset
REQ-025 SHALL, when rst is high at a clock edge, in any state including mid-SHIFT, enter IDLE, discard the operation, and drive in_ready=1, out_valid=0, busy=0, out_data=0, remaining=0 from the next cycle.

Configuration
REQ-026 SHALL, when macro MULTI_CYCLE_SHIFT_ARITH_EN is defined, fill vacated bits with the latched operand MSB on right shifts when the latched in_arith=1; left shifts unaffected.
REQ-027 SHALL, when MULTI_CYCLE_SHIFT_ARITH_EN is undefined, keep port in_arith, neither register nor use it, and perform logical shifts only.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, SHIFT, DONE) and the direction constants (DIR_LEFT=0, DIR_RIGHT=1) in package multi_cycle_shift_pkg.
REQ-029 SHALL instantiate one combinational sub-module shift_step (params N, STEP; inputs value, k, dir, fill bit; output shifted value) for the per-cycle shift.

Verification (N=8, STEP=3)
REQ-030 SHALL cover right: in_data=8'hB6, in_amt=5, in_dir=1 -> 2 SHIFT cycles, out_valid 3 cycles after acceptance, out_data=8'h05.
REQ-031 SHALL cover left: in_data=8'h01, in_amt=7, in_dir=0 -> 3 SHIFT cycles (3,3,1), out_valid 4 cycles after acceptance, out_data=8'h80.
REQ-032 SHALL cover zero distance: in_data=8'h5A, in_amt=0 -> no SHIFT, out_valid 1 cycle after acceptance, out_data=8'h5A.
REQ-033 SHALL cover backpressure: out_ready low 5 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout; IDLE the cycle after out_ready rises.
REQ-034 SHALL cover reset mid-operation: rst=1 during second SHIFT cycle of in_amt=7 -> next cycle in_ready=1, out_valid=0, busy=0, out_data=0; no result ever emitted.
REQ-035 SHALL cover arithmetic (macro defined): in_data=8'h96, in_amt=2, in_dir=1, in_arith=1 -> out_data=8'hE5; macro undefined -> out_data=8'h25.

Source files
------------

// File: rtl/multi_cycle_shift_pkg.sv
// Shared types for the multi-cycle shift sequencer: FSM states and
// shift-direction encodings.
package multi_cycle_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : multi_cycle_shift_pkg

// File: rtl/multi_cycle_shift_sequencer_shift_step.sv
// shift_step: one combinational shift of up to STEP positions.
// Left shifts fill with zeros; right shifts fill with i_fill.
module shift_step
  import multi_cycle_shift_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 3
) (
  input  logic [N-1:0]         i_value,
  input  logic [$clog2(N)-1:0] i_k,
  input  logic                 i_dir,
  input  logic                 i_fill,
  output logic [N-1:0]         o_value
);

  logic [N-1:0] w_fill_mask;

  // Mask of the vacated upper bits of a right shift by i_k.
  assign w_fill_mask = ~({N{1'b1}} >> i_k);

  // Select shift direction and apply the fill pattern on right shifts.
  always_comb begin
    if (i_dir == DIR_RIGHT) begin
      o_value = (i_value >> i_k) | (i_fill ? w_fill_mask : '0);
    end else begin
      o_value = i_value << i_k;
    end
  end

endmodule : shift_step

// File: rtl/multi_cycle_shift_sequencer.sv
// multi_cycle_shift_sequencer: accepts an operand and a shift distance,
// shifts at most STEP positions per cycle, then holds the result until
// the consumer takes it.
// Optional feature: define MULTI_CYCLE_SHIFT_ARITH_EN to honour in_arith
// (sign-fill on right shifts). Otherwise in_arith is ignored.
module multi_cycle_shift_sequencer
  import multi_cycle_shift_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_amt,
  input  logic                 in_dir,
  input  logic                 in_arith,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 busy
);

  localparam int AW = $clog2(N);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [N-1:0]    r_data;
  logic [AW-1:0]   r_rem;
  logic            r_dir;
  logic [AW-1:0]   w_k;
  logic [N-1:0]    w_shifted;
  logic            w_fill;
  logic            w_accept;

  assign w_accept = in_valid && in_ready;

  // Distance for this cycle: whatever remains, capped at STEP.
  assign w_k = (r_rem > AW'(STEP)) ? AW'(STEP) : r_rem;

`ifdef MULTI_CYCLE_SHIFT_ARITH_EN
  logic r_arith;

  // Latch the arithmetic request with the operand; cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arith <= 1'b0;
    end else if (w_accept) begin
      r_arith <= in_arith;
    end
  end

  // During a right shift the working MSB never changes under sign fill,
  // so it is the latched operand MSB.
  assign w_fill = r_arith && (r_dir == DIR_RIGHT) && r_data[N-1];
`else
  logic w_unused_arith;

  assign w_unused_arith = in_arith;
  assign w_fill         = 1'b0;
`endif

  shift_step #(
    .N    (N),
    .STEP (STEP)
  ) u_shift_step (
    .i_value (r_data),
    .i_k     (w_k),
    .i_dir   (r_dir),
    .i_fill  (w_fill),
    .o_value (w_shifted)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_state_nxt = (in_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (r_rem == w_k) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Working register and remaining count: load on accept, step in SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_rem  <= '0;
      r_dir  <= DIR_LEFT;
    end else if (w_accept) begin
      r_data <= in_data;
      r_rem  <= in_amt;
      r_dir  <= in_dir;
    end else if (r_state == SHIFT) begin
      r_data <= w_shifted;
      r_rem  <= r_rem - w_k;
    end
  end

  assign out_data = r_data;

endmodule : multi_cycle_shift_sequencer
